// File: rtl/sq_drain_ctrl_pkg.sv
// Shared types and sizing constants for the store-queue drain controller.
package sq_drain_ctrl_pkg;

    localparam int SQ_SZ           = 8;
    localparam int RET_W           = 2;
    localparam int DRAIN_HI        = 6;
    localparam int NUM_SQ_BITS     = $clog2(SQ_SZ + 1);
    localparam int NUM_SCALAR_BITS = $clog2(RET_W + 1);

    localparam logic [NUM_SQ_BITS-1:0] DRAIN_HI_CNT = NUM_SQ_BITS'(DRAIN_HI);
    localparam logic [NUM_SQ_BITS-1:0] SQ_SZ_CNT    = NUM_SQ_BITS'(SQ_SZ);
    localparam logic [NUM_SQ_BITS:0]   SQ_SZ_WIDE   = (NUM_SQ_BITS + 1)'(SQ_SZ);

    typedef enum logic [1:0] {
        MEM_BYTE   = 2'h0,
        MEM_HALF   = 2'h1,
        MEM_WORD   = 2'h2,
        MEM_DOUBLE = 2'h3
    } mem_size_e;

    typedef enum logic [1:0] {
        SQD_IDLE,
        SQD_REQ,
        SQD_WAIT
    } sq_drain_state_e;

    typedef struct packed {
        logic        valid;
        logic        is_store;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } dcache_req_t;

    // Port arbitration while idle: a nearly full queue forces stores,
    // otherwise stores and loads alternate when both want the port.
    function automatic logic store_wins(input logic store_ok,
                                        input logic urgent,
                                        input logic ld_req,
                                        input logic last_was_store);
        if (!store_ok) return 1'b0;
        if (urgent)    return 1'b1;
        if (ld_req)    return !last_was_store;
        return 1'b1;
    endfunction

endpackage

// File: rtl/sq_drain_ctrl.sv
// Drains retired stores from the store-queue head into the shared D-cache
// port, one store in flight at a time, and lets load misses use the port
// in between.
module sq_drain_ctrl
    import sq_drain_ctrl_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_SCALAR_BITS-1:0] stores_retiring,
    input  logic                       sq_head_valid,
    input  logic [31:0]                sq_head_addr,
    input  logic [31:0]                sq_head_data,
    input  logic [1:0]                 sq_head_size,
    output logic                       sq_pop,
    input  logic                       ld_req,
    input  logic [31:0]                ld_addr,
    output logic                       ld_gnt,
    output logic                       dc_req_valid,
    output logic                       dc_req_is_store,
    output logic [31:0]                dc_req_addr,
    output logic [31:0]                dc_req_data,
    output logic [1:0]                 dc_req_size,
    input  logic                       dc_req_ready,
    input  logic                       dc_st_ack,
    output logic [NUM_SQ_BITS-1:0]     pending_commits,
    output logic                       sq_drained
);

    sq_drain_state_e            state;
    logic [NUM_SQ_BITS-1:0]     pending;
    logic                       last_was_store;

    logic                       store_ok;
    logic                       pick_store;
    logic                       pick_load;
    logic                       pop;
    logic [NUM_SQ_BITS:0]       pending_sum;
    logic [NUM_SQ_BITS:0]       pending_after;
    logic [NUM_SQ_BITS-1:0]     pending_nxt;
    dcache_req_t                req;

    // Decide who owns the port this cycle and when the head store completes.
    always_comb begin
        store_ok   = (pending != '0) && sq_head_valid;
        pick_store = (state == SQD_IDLE) &&
                     store_wins(store_ok, pending >= DRAIN_HI_CNT, ld_req, last_was_store);
        pick_load  = (state == SQD_IDLE) && ld_req && !pick_store;
        pop        = (state == SQD_WAIT) && dc_st_ack;
    end

    // Next pending count: add retirements, remove the completed store, never above queue depth.
    always_comb begin
        pending_sum   = {1'b0, pending} + (NUM_SQ_BITS + 1)'(stores_retiring);
        pending_after = pending_sum - (NUM_SQ_BITS + 1)'(pop);
        pending_nxt   = (pending_after > SQ_SZ_WIDE) ? SQ_SZ_CNT
                                                     : pending_after[NUM_SQ_BITS-1:0];
    end

    // Build the D-cache request from the current state and the head/load inputs.
    always_comb begin
        req = '0;
        case (state)
            SQD_IDLE: begin
                if (pick_load) begin
                    req.valid    = 1'b1;
                    req.is_store = 1'b0;
                    req.addr     = ld_addr;
                    req.data     = '0;
                    req.size     = MEM_WORD;
                end
            end
            SQD_REQ: begin
                req.valid    = 1'b1;
                req.is_store = 1'b1;
                req.addr     = sq_head_addr;
                req.data     = sq_head_data;
                req.size     = sq_head_size;
            end
            default: begin
                req = '0;
            end
        endcase
    end

    assign dc_req_valid    = req.valid;
    assign dc_req_is_store = req.is_store;
    assign dc_req_addr     = req.addr;
    assign dc_req_data     = req.data;
    assign dc_req_size     = req.size;
    assign ld_gnt          = pick_load && dc_req_ready;
    assign sq_pop          = pop;
    assign pending_commits = pending;
    assign sq_drained      = (pending == '0) && (state == SQD_IDLE);

    // Drain sequencer, pending counter and the alternation flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= SQD_IDLE;
            pending        <= '0;
            last_was_store <= 1'b0;
        end else begin
            pending <= pending_nxt;
            case (state)
                SQD_IDLE: begin
                    if (pick_store) begin
                        state <= SQD_REQ;
                    end else if (pick_load && dc_req_ready) begin
                        last_was_store <= 1'b0;
                    end
                end
                SQD_REQ: begin
                    if (dc_req_ready) begin
                        last_was_store <= 1'b1;
                        state          <= SQD_WAIT;
                    end
                end
                SQD_WAIT: begin
                    if (dc_st_ack) begin
                        state <= SQD_IDLE;
                    end
                end
                default: begin
                    state <= SQD_IDLE;
                end
            endcase
        end
    end

    // Guard against retire overflow and acks that arrive with no store outstanding.
    always @(posedge clock) begin
        if (!reset) begin
            a_no_overflow: assert (pending_sum <= SQ_SZ_WIDE);
            a_ack_in_wait: assert (!dc_st_ack || (state == SQD_WAIT));
        end
    end

endmodule

// File: tb/tb_sq_drain_ctrl.sv
// Self-checking bench for sq_drain_ctrl: directed scenarios followed by a
// randomized run against a transaction-level reference model.
module tb_sq_drain_ctrl;
    import sq_drain_ctrl_pkg::*;

    logic        clock;
    logic        reset;
    logic [1:0]  stores_retiring;
    logic        sq_head_valid;
    logic [31:0] sq_head_addr;
    logic [31:0] sq_head_data;
    logic [1:0]  sq_head_size;
    logic        sq_pop;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_gnt;
    logic        dc_req_valid;
    logic        dc_req_is_store;
    logic [31:0] dc_req_addr;
    logic [31:0] dc_req_data;
    logic [1:0]  dc_req_size;
    logic        dc_req_ready;
    logic        dc_st_ack;
    logic [3:0]  pending_commits;
    logic        sq_drained;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  s;
    } ent_t;

    ent_t m_q[$];

    sq_drain_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .stores_retiring (stores_retiring),
        .sq_head_valid   (sq_head_valid),
        .sq_head_addr    (sq_head_addr),
        .sq_head_data    (sq_head_data),
        .sq_head_size    (sq_head_size),
        .sq_pop          (sq_pop),
        .ld_req          (ld_req),
        .ld_addr         (ld_addr),
        .ld_gnt          (ld_gnt),
        .dc_req_valid    (dc_req_valid),
        .dc_req_is_store (dc_req_is_store),
        .dc_req_addr     (dc_req_addr),
        .dc_req_data     (dc_req_data),
        .dc_req_size     (dc_req_size),
        .dc_req_ready    (dc_req_ready),
        .dc_st_ack       (dc_st_ack),
        .pending_commits (pending_commits),
        .sq_drained      (sq_drained)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_head(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        sq_head_valid = v;
        sq_head_addr  = a;
        sq_head_data  = d;
        sq_head_size  = s;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        stores_retiring = 2'd2;
        ld_req = 1'b0;
        ld_addr = '0;
        dc_req_ready = 1'b0;
        dc_st_ack = 1'b0;
        set_head(1'b0, 32'h0, 32'h0, MEM_WORD);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        stores_retiring = 2'd0;
        #1;
        n_checks++; if (pending_commits !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_pending got %0d want 0", pending_commits); end
        n_checks++; if (sq_drained !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_drained got %b want 1", sq_drained); end
        n_checks++; if (dc_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req_valid got %b want 0", dc_req_valid); end
        n_checks++; if (sq_pop !== 1'b0 || ld_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pop_gnt got %b%b want 00", sq_pop, ld_gnt); end
        tick();
        n_checks++; if (pending_commits !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_hold_pending got %0d want 0", pending_commits); end
    endtask

    task automatic test_single_store;
        set_head(1'b1, 32'h100, 32'hDEADBEEF, MEM_WORD);
        stores_retiring = 2'd1;
        dc_req_ready = 1'b1;
        tick();
        stores_retiring = 2'd0;
        #1;
        n_checks++; if (pending_commits !== 4'd1) begin n_fail++; $display("[TB] FAIL single_pending got %0d want 1", pending_commits); end
        n_checks++; if (dc_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_select_novalid got %b want 0", dc_req_valid); end
        n_checks++; if (sq_drained !== 1'b0) begin n_fail++; $display("[TB] FAIL single_drained got %b want 0", sq_drained); end
        tick();
        n_checks++; if (dc_req_valid !== 1'b1 || dc_req_is_store !== 1'b1) begin n_fail++; $display("[TB] FAIL single_req got v=%b st=%b want 1 1", dc_req_valid, dc_req_is_store); end
        n_checks++; if (dc_req_addr !== 32'h100 || dc_req_data !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL single_req_fields got %h/%h want 100/deadbeef", dc_req_addr, dc_req_data); end
        n_checks++; if (sq_pop !== 1'b0) begin n_fail++; $display("[TB] FAIL single_early_pop got %b want 0", sq_pop); end
        tick();
        dc_st_ack = 1'b1;
        #1;
        n_checks++; if (dc_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_wait_valid got %b want 0", dc_req_valid); end
        n_checks++; if (sq_pop !== 1'b1) begin n_fail++; $display("[TB] FAIL single_pop got %b want 1", sq_pop); end
        tick();
        dc_st_ack = 1'b0;
        set_head(1'b0, 32'h0, 32'h0, MEM_WORD);
        #1;
        n_checks++; if (pending_commits !== 4'd0 || sq_drained !== 1'b1) begin n_fail++; $display("[TB] FAIL single_done got p=%0d d=%b want 0 1", pending_commits, sq_drained); end
    endtask

    task automatic test_alternation;
        ld_req = 1'b1;
        ld_addr = 32'h3000;
        dc_req_ready = 1'b1;
        stores_retiring = 2'd2;
        set_head(1'b1, 32'h200, 32'h11111111, MEM_WORD);
        #1;
        n_checks++; if (ld_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL alt_prep_load got %b want 1", ld_gnt); end
        tick();
        stores_retiring = 2'd0;
        #1;
        n_checks++; if (dc_req_valid !== 1'b0 || ld_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL alt_store_first got v=%b g=%b want 0 0", dc_req_valid, ld_gnt); end
        tick();
        n_checks++; if (dc_req_is_store !== 1'b1 || dc_req_addr !== 32'h200 || ld_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL alt_req1 got st=%b a=%h g=%b want 1 200 0", dc_req_is_store, dc_req_addr, ld_gnt); end
        tick();
        dc_st_ack = 1'b1;
        #1;
        n_checks++; if (sq_pop !== 1'b1 || ld_gnt !== 1'b0 || dc_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL alt_wait1 got pop=%b g=%b v=%b want 1 0 0", sq_pop, ld_gnt, dc_req_valid); end
        tick();
        dc_st_ack = 1'b0;
        set_head(1'b1, 32'h204, 32'h22222222, MEM_WORD);
        #1;
        n_checks++; if (dc_req_valid !== 1'b1 || dc_req_is_store !== 1'b0 || dc_req_addr !== 32'h3000 || ld_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL alt_load got v=%b st=%b a=%h g=%b want 1 0 3000 1", dc_req_valid, dc_req_is_store, dc_req_addr, ld_gnt); end
        n_checks++; if (dc_req_size !== MEM_WORD || dc_req_data !== 32'h0) begin n_fail++; $display("[TB] FAIL alt_load_fields got sz=%0d d=%h want 2 0", dc_req_size, dc_req_data); end
        tick();
        n_checks++; if (dc_req_valid !== 1'b0 || ld_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL alt_store_second got v=%b g=%b want 0 0", dc_req_valid, ld_gnt); end
        tick();
        n_checks++; if (dc_req_is_store !== 1'b1 || dc_req_addr !== 32'h204 || ld_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL alt_req2 got st=%b a=%h g=%b want 1 204 0", dc_req_is_store, dc_req_addr, ld_gnt); end
        tick();
        dc_st_ack = 1'b1;
        #1;
        n_checks++; if (sq_pop !== 1'b1 || ld_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL alt_wait2 got pop=%b g=%b want 1 0", sq_pop, ld_gnt); end
        tick();
        dc_st_ack = 1'b0;
        ld_req = 1'b0;
        set_head(1'b0, 32'h0, 32'h0, MEM_WORD);
        #1;
        n_checks++; if (pending_commits !== 4'd0) begin n_fail++; $display("[TB] FAIL alt_pending got %0d want 0", pending_commits); end
    endtask

    task automatic test_drain_hi;
        bit acc;
        bit done;
        set_head(1'b0, 32'h0, 32'h0, MEM_WORD);
        ld_req = 1'b0;
        stores_retiring = 2'd2;
        repeat (3) tick();
        stores_retiring = 2'd0;
        ld_req = 1'b1;
        ld_addr = 32'h5550;
        dc_req_ready = 1'b1;
        set_head(1'b1, 32'h400, 32'h44444444, MEM_WORD);
        #1;
        n_checks++; if (pending_commits !== 4'd6) begin n_fail++; $display("[TB] FAIL hi_pending got %0d want 6", pending_commits); end
        n_checks++; if (dc_req_valid !== 1'b0 || ld_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL hi_store_wins got v=%b g=%b want 0 0", dc_req_valid, ld_gnt); end
        tick();
        n_checks++; if (dc_req_is_store !== 1'b1 || dc_req_addr !== 32'h400) begin n_fail++; $display("[TB] FAIL hi_req got st=%b a=%h want 1 400", dc_req_is_store, dc_req_addr); end
        tick();
        dc_st_ack = 1'b1;
        tick();
        dc_st_ack = 1'b0;
        #1;
        n_checks++; if (pending_commits !== 4'd5 || ld_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL hi_below_load got p=%0d g=%b want 5 1", pending_commits, ld_gnt); end
        ld_req = 1'b0;
        acc = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 80; k++) begin
            dc_st_ack = acc;
            #1;
            if (sq_drained) begin
                done = 1'b1;
                break;
            end
            acc = dc_req_valid && dc_req_is_store && dc_req_ready;
            @(posedge clock);
            #1;
        end
        dc_st_ack = 1'b0;
        n_checks++; if (!done) begin n_fail++; $display("[TB] FAIL hi_drain_timeout got pending=%0d want drained", pending_commits); end
        set_head(1'b0, 32'h0, 32'h0, MEM_WORD);
    endtask

    task automatic test_same_cycle;
        tick();
        stores_retiring = 2'd2;
        tick();
        stores_retiring = 2'd1;
        tick();
        stores_retiring = 2'd0;
        set_head(1'b1, 32'h500, 32'h55555555, MEM_WORD);
        dc_req_ready = 1'b1;
        tick();
        tick();
        dc_st_ack = 1'b1;
        stores_retiring = 2'd2;
        #1;
        n_checks++; if (pending_commits !== 4'd3 || sq_pop !== 1'b1) begin n_fail++; $display("[TB] FAIL same_before got p=%0d pop=%b want 3 1", pending_commits, sq_pop); end
        tick();
        dc_st_ack = 1'b0;
        stores_retiring = 2'd0;
        #1;
        n_checks++; if (pending_commits !== 4'd4) begin n_fail++; $display("[TB] FAIL same_after got %0d want 4", pending_commits); end
    endtask

    task automatic test_ready_stall;
        set_head(1'b1, 32'h504, 32'hCAFE0001, MEM_HALF);
        dc_req_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (dc_req_valid !== 1'b1 || dc_req_is_store !== 1'b1 || dc_req_addr !== 32'h504 || dc_req_data !== 32'hCAFE0001 || dc_req_size !== MEM_HALF) begin
                n_fail++; $display("[TB] FAIL stall_stable[%0d] got v=%b a=%h d=%h s=%0d want 1 504 cafe0001 1", i, dc_req_valid, dc_req_addr, dc_req_data, dc_req_size);
            end
            tick();
        end
        dc_req_ready = 1'b1;
        tick();
        dc_req_ready = 1'b0;
        n_checks++; if (dc_req_valid !== 1'b0 || sq_drained !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_wait got v=%b d=%b want 0 0", dc_req_valid, sq_drained); end
        #2;
        reset = 1'b1;
        dc_st_ack = 1'b1;
        #1;
        n_checks++; if (sq_pop !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_wait_pop got %b want 0", sq_pop); end
        n_checks++; if (pending_commits !== 4'd0 || sq_drained !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_wait_state got p=%0d d=%b want 0 1", pending_commits, sq_drained); end
        dc_st_ack = 1'b0;
        set_head(1'b0, 32'h0, 32'h0, MEM_WORD);
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_random;
        ent_t e;
        int pend;
        int n;
        int allow;
        int cd;
        bit busy;
        bit accd;
        bit lws;
        bit hv;
        bit st_ok;
        bit pick_s;
        bit pick_l;
        pend = 0;
        busy = 0;
        accd = 0;
        lws = 0;
        cd = 0;
        m_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            allow = SQ_SZ - pend;
            n = $urandom_range(0, (allow < 2) ? allow : 2);
            ld_req = 1'($urandom_range(0, 1));
            ld_addr = $urandom;
            dc_req_ready = ($urandom_range(0, 3) != 0);
            dc_st_ack = accd && (cd == 0);
            hv = (m_q.size() > 0) && (busy || ($urandom_range(0, 4) != 0));
            if (m_q.size() > 0) set_head(hv, m_q[0].a, m_q[0].d, m_q[0].s);
            else set_head(1'b0, $urandom, $urandom, 2'($urandom_range(0, 3)));
            stores_retiring = 2'(n);
            #1;
            n_checks++; if (pending_commits !== 4'(pend)) begin n_fail++; $display("[TB] FAIL rnd_pending cyc %0d got %0d want %0d", cyc, pending_commits, pend); end
            if (!busy) begin
                st_ok = (pend > 0) && hv;
                pick_s = st_ok && ((pend >= DRAIN_HI) || !ld_req || !lws);
                pick_l = ld_req && !pick_s;
                n_checks++; if (dc_req_valid !== pick_l || ld_gnt !== (pick_l && dc_req_ready)) begin n_fail++; $display("[TB] FAIL rnd_idle_arb cyc %0d got v=%b g=%b want %b %b", cyc, dc_req_valid, ld_gnt, pick_l, pick_l && dc_req_ready); end
                n_checks++; if (sq_pop !== 1'b0 || sq_drained !== (pend == 0)) begin n_fail++; $display("[TB] FAIL rnd_idle_flags cyc %0d got pop=%b d=%b want 0 %b", cyc, sq_pop, sq_drained, pend == 0); end
                if (pick_l) begin
                    n_checks++; if (dc_req_is_store !== 1'b0 || dc_req_addr !== ld_addr || dc_req_data !== 32'h0 || dc_req_size !== MEM_WORD) begin n_fail++; $display("[TB] FAIL rnd_load cyc %0d got st=%b a=%h d=%h s=%0d", cyc, dc_req_is_store, dc_req_addr, dc_req_data, dc_req_size); end
                end
                if (pick_s) busy = 1;
                else if (pick_l && dc_req_ready) lws = 0;
            end else if (!accd) begin
                n_checks++; if (dc_req_valid !== 1'b1 || dc_req_is_store !== 1'b1 || dc_req_addr !== m_q[0].a || dc_req_data !== m_q[0].d || dc_req_size !== m_q[0].s) begin
                    n_fail++; $display("[TB] FAIL rnd_store cyc %0d got v=%b st=%b a=%h d=%h want a=%h d=%h", cyc, dc_req_valid, dc_req_is_store, dc_req_addr, dc_req_data, m_q[0].a, m_q[0].d);
                end
                n_checks++; if (ld_gnt !== 1'b0 || sq_pop !== 1'b0 || sq_drained !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_req_flags cyc %0d got g=%b pop=%b d=%b want 0 0 0", cyc, ld_gnt, sq_pop, sq_drained); end
                if (dc_req_ready) begin
                    accd = 1;
                    lws = 1;
                    cd = $urandom_range(0, 2);
                end
            end else begin
                n_checks++; if (dc_req_valid !== 1'b0 || ld_gnt !== 1'b0 || sq_pop !== dc_st_ack || sq_drained !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_wait cyc %0d got v=%b g=%b pop=%b d=%b want 0 0 %b 0", cyc, dc_req_valid, ld_gnt, sq_pop, sq_drained, dc_st_ack); end
                if (dc_st_ack) begin
                    void'(m_q.pop_front());
                    pend--;
                    busy = 0;
                    accd = 0;
                end else begin
                    cd--;
                end
            end
            for (int j = 0; j < n; j++) begin
                e.a = {$urandom_range(0, 32'hFFFF), 2'b00} & 32'h0003FFFC;
                e.d = $urandom;
                e.s = 2'($urandom_range(0, 3));
                m_q.push_back(e);
            end
            pend += n;
            @(posedge clock);
            #1;
        end
        stores_retiring = 2'd0;
        ld_req = 1'b0;
        dc_st_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_alternation();
        test_drain_hi();
        test_same_cycle();
        test_ready_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
